// File: rtl/tile_cache_ctrl.sv
// tile_cache_ctrl: miss handling, victim choice and line fill for a 4-bank tile cache
module tile_cache_ctrl #(
  parameter int TAG_W      = 9,
  parameter int OFF_W      = 7,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 8,
  parameter int BEAT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [OFF_W-1:0]  req_off,
  input  logic              hit,
  input  logic [3:0]        select,
  output logic [TAG_W-1:0]  bank_tag_0,
  output logic [TAG_W-1:0]  bank_tag_1,
  output logic [TAG_W-1:0]  bank_tag_2,
  output logic [TAG_W-1:0]  bank_tag_3,
  output logic              rsp_valid,
  output logic [1:0]        rsp_bank,
  output logic [OFF_W-1:0]  rsp_off,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              fill_we,
  output logic [1:0]        fill_bank,
  output logic [BEAT_W-1:0] fill_beat,
  output logic [DATA_W-1:0] fill_data
);
  typedef enum logic [1:0] {IDLE, MREQ, FILL, RESP} state_t;
  state_t                  state_q, state_d;
  logic [3:0][TAG_W-1:0]   tag_q, tag_d;
  logic [3:0]              valid_q, valid_d, qsel;
  logic [1:0]              rr_q, rr_d, victim_q, victim_d, rsp_bank_q, rsp_bank_d, hit_bank, free_bank;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [TAG_W-1:0]        lt_tag_q, lt_tag_d;
  logic [OFF_W-1:0]        lt_off_q, lt_off_d, rsp_off_q, rsp_off_d;
  logic                    rsp_valid_q, rsp_valid_d, accept, qhit, last;
  assign qsel      = select & valid_q;
  assign qhit      = hit & |qsel;
  assign hit_bank  = qsel[0] ? 2'd0 : qsel[1] ? 2'd1 : qsel[2] ? 2'd2 : 2'd3;
  assign free_bank = !valid_q[0] ? 2'd0 : !valid_q[1] ? 2'd1 : !valid_q[2] ? 2'd2 : 2'd3;
  assign req_ready = state_q == IDLE;
  assign accept    = req_valid & req_ready;
  assign fill_we   = state_q == FILL & mem_data_valid;
  assign last      = fill_we & (beat_q == BEAT_W'(LINE_BEATS - 1));
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    lt_tag_d    = lt_tag_q;
    lt_off_d    = lt_off_q;
    rsp_valid_d = 1'b0;
    rsp_bank_d  = rsp_bank_q;
    rsp_off_d   = rsp_off_q;
    if (accept && qhit) begin
      rsp_valid_d = 1'b1;
      rsp_bank_d  = hit_bank;
      rsp_off_d   = req_off;
    end
    if (accept && !qhit) begin
      lt_tag_d = req_tag;
      lt_off_d = req_off;
      victim_d = &valid_q ? rr_q : free_bank;
      state_d  = MREQ;
    end
    if (state_q == MREQ && mem_req_ready) begin
      state_d = FILL;
      beat_d  = '0;
    end
    if (fill_we) beat_d = beat_q + BEAT_W'(1);
    if (last) begin
      tag_d[victim_q]   = lt_tag_q;
      valid_d[victim_q] = 1'b1;
      rr_d              = &valid_q ? rr_q + 2'd1 : rr_q;
      rsp_valid_d       = 1'b1;
      rsp_bank_d        = victim_q;
      rsp_off_d         = lt_off_q;
      state_d           = RESP;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      valid_q     <= '0;
      rr_q        <= '0;
      victim_q    <= '0;
      beat_q      <= '0;
      lt_tag_q    <= '0;
      lt_off_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
      rsp_off_q   <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      victim_q    <= victim_d;
      beat_q      <= beat_d;
      lt_tag_q    <= lt_tag_d;
      lt_off_q    <= lt_off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bank_q  <= rsp_bank_d;
      rsp_off_q   <= rsp_off_d;
    end
  end
  assign bank_tag_0    = tag_q[0];
  assign bank_tag_1    = tag_q[1];
  assign bank_tag_2    = tag_q[2];
  assign bank_tag_3    = tag_q[3];
  assign rsp_valid     = rsp_valid_q;
  assign rsp_bank      = rsp_bank_q;
  assign rsp_off       = rsp_off_q;
  assign mem_req_valid = state_q == MREQ;
  assign mem_req_tag   = lt_tag_q;
  assign fill_bank     = victim_q;
  assign fill_beat     = beat_q;
  assign fill_data     = fill_we ? mem_data : '0;
endmodule

// File: tb/tb_tile_cache_ctrl.sv
// tb_tile_cache_ctrl: directed checks of hits, misses, round-robin eviction and reset abort
module tb_tile_cache_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, hit = 1'b0;
  logic [8:0]  req_tag = '0;
  logic [6:0]  req_off = '0;
  logic [3:0]  select = '0;
  logic [8:0]  bank_tag_0, bank_tag_1, bank_tag_2, bank_tag_3, mem_req_tag;
  logic        rsp_valid, mem_req_valid, mem_req_ready = 1'b0, mem_data_valid = 1'b0, fill_we;
  logic [1:0]  rsp_bank, fill_bank;
  logic [6:0]  rsp_off;
  logic [31:0] mem_data = '0, fill_data;
  logic [2:0]  fill_beat;
  logic [8:0]  model_tag [4];
  int          n_chk = 0, n_pass = 0;

  tile_cache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_off(req_off), .hit(hit), .select(select),
    .bank_tag_0(bank_tag_0), .bank_tag_1(bank_tag_1), .bank_tag_2(bank_tag_2), .bank_tag_3(bank_tag_3),
    .rsp_valid(rsp_valid), .rsp_bank(rsp_bank), .rsp_off(rsp_off),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_tag(mem_req_tag),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fill_we(fill_we), .fill_bank(fill_bank), .fill_beat(fill_beat), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] btag(input int i);
    return i == 0 ? bank_tag_0 : i == 1 ? bank_tag_1 : i == 2 ? bank_tag_2 : bank_tag_3;
  endfunction

  function automatic logic [31:0] pat(input logic [8:0] t, input int b);
    return 32'hA500_0000 + ({23'd0, t} << 8) + 32'(b);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared;
    for (int i = 0; i < 4; i++) chk("tag_cleared", btag(i), 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_fill_we", fill_we, 0);
  endtask

  task automatic do_hit(input logic [8:0] t, input logic [6:0] o, input logic [3:0] s, input logic [1:0] eb);
    req_valid = 1; req_tag = t; req_off = o; hit = 1; select = s;
    tick;
    req_valid = 0; hit = 0; select = 0;
    chk("hit_rsp_valid", rsp_valid, 1);
    chk("hit_rsp_bank", rsp_bank, eb);
    chk("hit_rsp_off", rsp_off, o);
    chk("hit_no_mem_req", mem_req_valid, 0);
    chk("hit_req_ready", req_ready, 1);
    tick;
    chk("hit_rsp_pulse", rsp_valid, 0);
  endtask

  task automatic do_miss(input logic [8:0] t, input logic [6:0] o, input logic h, input logic [3:0] s,
                         input logic [1:0] eb, input int dly, input bit gappy);
    int beats, cyc, we;
    bit rdy_ok;
    req_valid = 1; req_tag = t; req_off = o; hit = h; select = s;
    #1;
    chk("miss_accept_ready", req_ready, 1);
    tick;
    req_valid = 0; hit = 0; select = 0;
    chk("mreq_valid", mem_req_valid, 1);
    chk("mreq_tag", mem_req_tag, t);
    chk("mreq_no_rsp", rsp_valid, 0);
    for (int i = 0; i < dly; i++) begin
      tick;
      chk("mreq_held", {mem_req_valid, 7'd0, mem_req_tag}, {1'b1, 7'd0, t});
    end
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    chk("fill_mreq_drop", mem_req_valid, 0);
    beats = 0; cyc = 0; we = 0; rdy_ok = 1;
    while (beats < 8 && cyc < 64) begin
      mem_data_valid = gappy ? (cyc % 2 == 0) : 1'b1;
      mem_data = pat(t, beats);
      #1;
      if (req_ready) rdy_ok = 0;
      chk("fill_we", fill_we, mem_data_valid);
      if (fill_we) begin
        we++;
        chk("fill_beat", fill_beat, beats);
        chk("fill_bank", fill_bank, eb);
        chk("fill_data", fill_data, pat(t, beats));
        if (beats == 4) chk("old_tag_mid_fill", btag(eb), model_tag[eb]);
        beats++;
      end
      tick;
      cyc++;
    end
    mem_data_valid = 0;
    chk("beats_done", beats, 8);
    chk("fill_we_count", we, 8);
    chk("req_ready_low_in_fill", rdy_ok, 1);
    model_tag[eb] = t;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_bank", rsp_bank, eb);
    chk("resp_off", rsp_off, o);
    chk("resp_req_ready", req_ready, 0);
    chk("new_tag", btag(eb), t);
    tick;
    chk("resp_pulse", rsp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask

  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i < 4; i++) model_tag[i] = '0;
    check_cleared;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model_tag[i] = '0;
    tick;
    tick;
    rst = 0;
    check_cleared;
    do_miss(9'h000, 7'h15, 1'b1, 4'b0001, 2'd0, 0, 0);
    do_hit(9'h000, 7'h2A, 4'b0001, 2'd0);
    do_reset;
    do_miss(9'h011, 7'h01, 1'b0, 4'b0000, 2'd0, 0, 0);
    do_miss(9'h022, 7'h02, 1'b0, 4'b0000, 2'd1, 3, 1);
    do_miss(9'h033, 7'h03, 1'b0, 4'b0000, 2'd2, 1, 0);
    do_miss(9'h044, 7'h04, 1'b0, 4'b0000, 2'd3, 0, 0);
    do_hit(9'h033, 7'h5C, 4'b0100, 2'd2);
    do_hit(9'h022, 7'h11, 4'b0110, 2'd1);
    do_miss(9'h055, 7'h05, 1'b0, 4'b0000, 2'd0, 0, 0);
    do_miss(9'h066, 7'h06, 1'b0, 4'b0000, 2'd1, 0, 1);
    do_miss(9'h077, 7'h07, 1'b0, 4'b0000, 2'd2, 2, 0);
    chk("evicted_bank0", bank_tag_0, 9'h055);
    do_hit(9'h044, 7'h44, 4'b1000, 2'd3);
    req_valid = 1; req_tag = 9'h088; req_off = 7'h08;
    tick;
    req_valid = 0;
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    for (int b = 0; b < 5; b++) begin
      mem_data_valid = 1; mem_data = pat(9'h088, b);
      if (b == 4) rst = 1;
      #1;
      chk("abort_fill_beat", fill_beat, b);
      chk("abort_fill_bank", fill_bank, 2'd3);
      tick;
    end
    rst = 0;
    for (int i = 0; i < 4; i++) model_tag[i] = '0;
    check_cleared;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_fill_we", fill_we, 0);
      chk("abort_no_rsp", rsp_valid, 0);
      tick;
    end
    mem_data_valid = 0;
    do_miss(9'h099, 7'h09, 1'b1, 4'b1111, 2'd0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tile_cache_ctrl.md
Name: tile_cache_ctrl

Overview:
- Miss-handling controller for the rasterizer's 4-bank tile cache.
- Sits directly downstream of the bank tag-compare stage. It owns the four bank tags that feed the compare stage and consumes that stage's hit/select result.
- On a hit it returns the bank index. On a miss it picks a victim bank, fetches the line from memory beat by beat, writes it into the bank, updates the tag, then responds.

Parameters:
- TAG_W, 9, tag width; matches the compare stage.
- OFF_W, 7, in-line offset width; passed through unchanged.
- DATA_W, 32, memory beat width.
- LINE_BEATS, 8, beats per line fill; power of 2, ≥2.
- BEAT_W, 3, log2(LINE_BEATS).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  pixel request valid
- req_ready  out  1  controller can accept a request
- req_tag  in  TAG_W  request tag; also drives the compare stage tag_in
- req_off  in  OFF_W  request offset
- hit  in  1  compare-stage hit; combinational from req_tag
- select  in  4  compare-stage one-hot/multi-hot bank match
- bank_tag_0..bank_tag_3  out  TAG_W each  stored tags to the compare stage
- rsp_valid  out  1  response strobe
- rsp_bank  out  2  bank index holding the line
- rsp_off  out  OFF_W  echoed offset
- mem_req_valid  out  1  line fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_tag  out  TAG_W  tag to fetch
- mem_data_valid  in  1  one fill beat present
- mem_data  in  DATA_W  fill beat data
- fill_we  out  1  bank write enable
- fill_bank  out  2  bank being written
- fill_beat  out  BEAT_W  beat index within the line
- fill_data  out  DATA_W  write data

Behaviour:
- Reset is rst, synchronous, active-high.
- Reset values:
  - state IDLE
  - all bank_tag_N = 0, valid[3:0] = 0
  - rr_ptr = 0, beat_cnt = 0
  - all outputs 0 except req_ready, which follows state (1 in IDLE)
- States: IDLE, MREQ, FILL, RESP.
- req_ready = 1 only in IDLE; a request is accepted when req_valid & req_ready.
- Qualified hit: qsel = select & valid; qhit = hit & |qsel.
  - A select bit on an invalid bank is ignored, so a reset-time tag 0 never hits.
  - If several qsel bits are set, the lowest index wins.
- IDLE, accept with qhit:
  - Next cycle rsp_valid = 1 for one cycle, with rsp_bank = encoded qsel and rsp_off = req_off.
  - State stays IDLE; back-to-back hits give one response per cycle, 1-cycle latency.
- IDLE, accept without qhit:
  - Latch tag/off.
  - Choose victim: lowest-index invalid bank; if all are valid, rr_ptr.
  - Go to MREQ.
- MREQ:
  - mem_req_valid = 1 and mem_req_tag = latched tag, held stable until mem_req_ready.
  - On mem_req_ready, go to FILL with beat_cnt = 0.
- FILL:
  - Each cycle mem_data_valid = 1: fill_we = 1 that cycle, combinationally, with fill_bank = victim, fill_beat = beat_cnt, fill_data = mem_data; then beat_cnt increments.
  - Cycles without mem_data_valid: fill_we = 0, no progress.
  - Gaps between beats are allowed; beats arriving in MREQ or IDLE are ignored.
  - On the beat with beat_cnt = LINE_BEATS-1:
    - bank_tag[victim] <= latched tag, valid[victim] <= 1.
    - If all banks were already valid, rr_ptr <= rr_ptr+1, wrapping 3→0.
    - Go to RESP.
- RESP: rsp_valid = 1 for one cycle with rsp_bank = victim and rsp_off = latched offset; then IDLE.
- Miss latency = memory handshake + LINE_BEATS beats + 1 cycle.
- Tags and valid bits change only at the final fill beat. During a fill the old victim tag stays visible, so it is never half-updated.
- Reset mid-MREQ or mid-FILL: aborts immediately. All tags and valid bits are cleared, no response is issued, and later beats are ignored.
- Only one miss is outstanding at a time; no hit-under-miss.

Test Plan:
- Reset, then request tag 0x000 with hit=1, select=0001 from the compare stage → treated as a miss (valid=0). mem_req_tag=0x000; victim bank 0 filled over 8 beats; rsp_bank=0; bank_tag_0=0x000.
- Fill banks 0–3 with tags 0x011, 0x022, 0x033, 0x044, then request 0x033 with select=0100 → rsp_valid one cycle after accept, rsp_bank=2, no mem_req_valid.
- With all four banks valid, three misses 0x055, 0x066, 0x077 → victims 0, 1, 2 in order (round-robin wrap); 0x011 is evicted from bank 0.
- During a fill, mem_data_valid toggles 1,0,1,... with mem_req_ready delayed 3 cycles → fill_beat runs 0..7 with no skips; fill_we is asserted exactly 8 times; req_ready stays 0 throughout.
- Assert rst during FILL at beat 4 → next cycle state is IDLE with req_ready=1 and all tags/valid=0; no rsp_valid; remaining beats produce no fill_we.
- Select=0110 with both banks valid → rsp_bank=1 (lowest-index priority).
